wb_slave_decoder: RTL and testbench
===================================

WB_SLAVE_DECODER -- requirements
Module: wb_slave_decoder

Interface
REQ-001 SHALL have parameter NSLAVES, default 3, meaning number of downstream slaves (1..16).
REQ-002 SHALL have parameter AW, default 30, meaning word-address width.
REQ-003 SHALL have parameter DW, default 32, meaning data width (multiple of 8).
REQ-004 SHALL have parameter PAGE_LSB, default 8, meaning lowest address bit compared during decode.
REQ-005 SHALL have parameter SLAVE_BASE, default {22'h083,22'h082,22'h081}, meaning flattened per-slave page values, slave 0 in the LSBs.
REQ-006 SHALL have parameter MAX_OUT, default 4, meaning maximum outstanding requests (1..15).
REQ-007 SHALL have parameter TIMEOUT, default 1024, meaning idle cycles before a pending request is aborted.
REQ-008 SHALL have port i_clk  in  1  sole clock; reset is synchronous and active-low on port i_resetb.
REQ-009 SHALL have port i_resetb  in  1  synchronous active-low reset.
REQ-010 SHALL have ports i_wb_cyc, i_wb_stb, i_wb_we  in  1  master bus controls.
REQ-011 SHALL have ports i_wb_addr  in  AW, and i_wb_data  in  DW, and i_wb_sel  in  DW/8, the master request fields.
REQ-012 SHALL have ports o_wb_stall, o_wb_ack, o_wb_err  out  1, and o_wb_data  out  DW, the master return fields.
REQ-013 SHALL have ports o_s_cyc, o_s_stb  out  NSLAVES  per-slave controls; we/addr/data/sel are shared pass-through.
REQ-014 SHALL have ports i_s_stall, i_s_ack  in  NSLAVES, and i_s_data  in  NSLAVES*DW  per-slave returns.
REQ-015 SHALL have ports o_err_addr  out  AW  last faulting address, and o_err_count  out  16  saturating error count.

Function
REQ-016 Slave k SHALL be selected when i_wb_addr[AW-1:PAGE_LSB]==SLAVE_BASE[k]; on overlap the lowest index wins; no match = unmapped.
REQ-017 A request SHALL be accepted on a cycle with i_wb_cyc && i_wb_stb && !o_wb_stall.
REQ-018 o_wb_stall SHALL be asserted when: outstanding==MAX_OUT; or outstanding>0 and target differs from owner slave (including unmapped); or the selected slave's i_s_stall is high; or state==ERR.
REQ-019 o_s_stb[k] SHALL equal i_wb_stb && selected==k && state!=ERR; o_s_cyc[k] SHALL be high while i_wb_cyc && (owner==k || selected==k) && state!=ERR.
REQ-020 States: IDLE (outstanding==0), BUSY (outstanding>0, owner latched), ERR (one-cycle abort); IDLE->BUSY on mapped accept; BUSY->IDLE when the last ack returns; BUSY->ERR on timeout; ERR->IDLE unconditionally.
REQ-021 Outstanding counter SHALL increment on accept, decrement on owner ack, and hold when both occur in the same cycle.
REQ-022 o_wb_ack SHALL be registered: asserted one cycle after i_s_ack[owner] while outstanding>0; o_wb_data SHALL register i_s_data of owner on that cycle and be zero otherwise.
REQ-023 Acks from non-owner slaves or with outstanding==0 SHALL be ignored.
REQ-024 An unmapped request SHALL be accepted only in IDLE and SHALL raise o_wb_err for exactly one cycle, one cycle after acceptance; no slave strobe.
REQ-025 Timeout counter SHALL clear on accept or owner ack and count while BUSY; reaching TIMEOUT SHALL pulse o_wb_err one cycle, clear outstanding and owner, enter ERR.
REQ-026 i_wb_cyc low SHALL clear outstanding, owner and timeout counter next cycle and suppress any pending ack/err.
REQ-027 On every o_wb_err, o_err_addr SHALL load the address of the faulting (unmapped or oldest pending) request and o_err_count SHALL increment, saturating at 16'hFFFF.

Reset
REQ-028 While i_resetb is low at a rising i_clk: state=IDLE, outstanding=0, owner=0, timeout=0, o_wb_ack=0, o_wb_err=0, o_wb_data=0, o_err_addr=0, o_err_count=0; o_s_cyc/o_s_stb/o_wb_stall SHALL be 0 during reset.
REQ-029 Reset mid-transaction SHALL discard all pending requests without any ack or err.

Structure
REQ-030 State enum, DEFAULT_TIMEOUT and page constants (0x081..0x083) SHALL live in shared package wb_bus_pkg.
REQ-031 Outstanding/timeout/owner logic SHALL be one sub-module wb_txn_tracker; decode and return mux stay in the top.

Verification
REQ-032 Write to page 0x082, slave 1 acks next cycle -> o_s_stb=3'b010 one cycle, o_wb_ack one cycle later, o_wb_err=0.
REQ-033 Four back-to-back reads to slave 0, MAX_OUT=4, acks delayed 3 cycles -> no stall for 4 accepts, 5th stalls, four acks in order with correct data.
REQ-034 Read to page 0x081 while slave 2 has 1 outstanding -> stalled until slave 2 ack, then issued to slave 0.
REQ-035 Access address 0x00000100 (unmapped) -> o_wb_err one cycle, o_err_addr=0x100, o_err_count=1.
REQ-036 Slave 0 never acks, TIMEOUT=16 -> o_wb_err at 16 idle cycles, ERR one cycle, late ack ignored, o_err_count increments.
REQ-037 Drop i_wb_cyc with 2 outstanding, or assert reset -> no ack/err issued, next request proceeds from IDLE.

Source files
------------

// File: rtl/wb_bus_pkg.sv
// Shared Wishbone decoder types and constants: transaction state, default
// timeout and the page numbers of the three standard downstream slaves.
package wb_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } wb_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 1024;
  localparam int unsigned PAGE_W          = 22;

  localparam logic [PAGE_W-1:0] PAGE_SLAVE0 = 22'h081;
  localparam logic [PAGE_W-1:0] PAGE_SLAVE1 = 22'h082;
  localparam logic [PAGE_W-1:0] PAGE_SLAVE2 = 22'h083;

  // Index width that stays legal when the indexed range has a single entry.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_txn_tracker.sv
// Tracks the outstanding requests of the current owner slave: count, owner,
// idle timeout and the addresses of pending requests (oldest first).
module wb_txn_tracker
  import wb_bus_pkg::*;
#(
  parameter int unsigned NSLAVES = 3,
  parameter int unsigned AW      = 30,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  localparam int unsigned OW     = idx_w(NSLAVES),
  localparam int unsigned CW     = $clog2(MAX_OUT + 1),
  localparam int unsigned TW     = $clog2(TIMEOUT + 1)
) (
  input  logic          i_clk,
  input  logic          i_resetb,
  input  logic          i_cyc,
  input  logic          i_accept,
  input  logic          i_mapped,
  input  logic [OW-1:0] i_slave,
  input  logic [AW-1:0] i_addr,
  input  logic          i_owner_ack,
  output wb_state_e     o_state,
  output logic [CW-1:0] o_outstanding,
  output logic [OW-1:0] o_owner,
  output logic [AW-1:0] o_oldest_addr_c,
  output logic          o_timeout_c
);

  localparam int unsigned PW = idx_w(MAX_OUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] addr_q [MAX_OUT];
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push = i_cyc && i_accept && i_mapped && (o_state != ST_ERR);
  assign pop  = i_cyc && i_owner_ack && (o_state == ST_BUSY);

  // An idle BUSY cycle with the counter at its last value aborts the burst.
  assign o_timeout_c = (o_state == ST_BUSY) && i_cyc && !i_accept &&
                       !i_owner_ack && (tmo_cnt == TMO_LAST);

  assign o_oldest_addr_c = addr_q[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (!i_resetb || !i_cyc) begin
      o_state       <= ST_IDLE;
      o_outstanding <= '0;
      o_owner       <= '0;
      tmo_cnt       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
    end else begin
      case (o_state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (push) begin
            o_state       <= ST_BUSY;
            o_outstanding <= CW'(1);
            o_owner       <= i_slave;
            wr_ptr        <= ptr_inc(wr_ptr);
          end
        end
        ST_BUSY: begin
          if (o_timeout_c) begin
            o_state       <= ST_ERR;
            o_outstanding <= '0;
            o_owner       <= '0;
            tmo_cnt       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
          end else begin
            tmo_cnt <= (i_accept || i_owner_ack) ? '0 : tmo_cnt + TW'(1);
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop) begin
              o_outstanding <= o_outstanding + CW'(1);
            end else if (pop && !push) begin
              o_outstanding <= o_outstanding - CW'(1);
              if (o_outstanding == CW'(1)) begin
                o_state <= ST_IDLE;
                o_owner <= '0;
              end
            end
          end
        end
        ST_ERR:  o_state <= ST_IDLE;
        default: o_state <= ST_IDLE;
      endcase
    end
  end

  // Pending-address storage needs no reset; only live entries are ever read.
  always_ff @(posedge i_clk) begin
    if (push) addr_q[wr_ptr] <= i_addr;
  end

endmodule

// File: rtl/wb_slave_decoder.sv
// Wishbone pipelined 1-to-N address decoder: page-based slave select, single
// owner while requests are pending, registered return mux and error reporting.
module wb_slave_decoder
  import wb_bus_pkg::*;
#(
  parameter int unsigned NSLAVES  = 3,
  parameter int unsigned AW       = 30,
  parameter int unsigned DW       = 32,
  parameter int unsigned PAGE_LSB = 8,
  parameter logic [NSLAVES*(AW-PAGE_LSB)-1:0] SLAVE_BASE =
    {PAGE_SLAVE2, PAGE_SLAVE1, PAGE_SLAVE0},
  parameter int unsigned MAX_OUT  = 4,
  parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic                  i_clk,
  input  logic                  i_resetb,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_stb,
  input  logic                  i_wb_we,
  input  logic [AW-1:0]         i_wb_addr,
  input  logic [DW-1:0]         i_wb_data,
  input  logic [DW/8-1:0]       i_wb_sel,
  output logic                  o_wb_stall,
  output logic                  o_wb_ack,
  output logic                  o_wb_err,
  output logic [DW-1:0]         o_wb_data,
  output logic [NSLAVES-1:0]    o_s_cyc,
  output logic [NSLAVES-1:0]    o_s_stb,
  output logic                  o_s_we,
  output logic [AW-1:0]         o_s_addr,
  output logic [DW-1:0]         o_s_data,
  output logic [DW/8-1:0]       o_s_sel,
  input  logic [NSLAVES-1:0]    i_s_stall,
  input  logic [NSLAVES-1:0]    i_s_ack,
  input  logic [NSLAVES*DW-1:0] i_s_data,
  output logic [AW-1:0]         o_err_addr,
  output logic [15:0]           o_err_count
);

  localparam int unsigned PGW = AW - PAGE_LSB;
  localparam int unsigned OW  = idx_w(NSLAVES);
  localparam int unsigned CW  = $clog2(MAX_OUT + 1);

  logic [PGW-1:0] page;
  logic           mapped;
  logic [OW-1:0]  sel;
  wb_state_e      state;
  logic [CW-1:0]  outstanding;
  logic [OW-1:0]  owner;
  logic [AW-1:0]  oldest_addr;
  logic           timeout_hit;
  logic           busy;
  logic           block;
  logic           slave_stall;
  logic           accept;
  logic           owner_ack_raw;
  logic           owner_ack;
  logic [DW-1:0]  owner_data;
  logic           unmapped_acc;
  logic           err_set;

  assign o_s_we   = i_wb_we;
  assign o_s_addr = i_wb_addr;
  assign o_s_data = i_wb_data;
  assign o_s_sel  = i_wb_sel;

  assign page = i_wb_addr[AW-1:PAGE_LSB];

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    mapped = 1'b0;
    sel    = '0;
    for (int k = NSLAVES - 1; k >= 0; k--) begin
      if (page == SLAVE_BASE[k*PGW +: PGW]) begin
        mapped = 1'b1;
        sel    = OW'(k);
      end
    end
  end

  always_comb begin
    owner_ack_raw = 1'b0;
    owner_data    = '0;
    slave_stall   = 1'b0;
    for (int k = 0; k < NSLAVES; k++) begin
      if (owner == OW'(k)) begin
        owner_ack_raw = i_s_ack[k];
        owner_data    = i_s_data[k*DW +: DW];
      end
      if (sel == OW'(k)) slave_stall = i_s_stall[k];
    end
  end

  assign busy  = (outstanding != '0);
  // Conditions under which no slave may see a strobe this cycle.
  assign block = (outstanding == CW'(MAX_OUT)) ||
                 (busy && (!mapped || (sel != owner))) ||
                 (state == ST_ERR);

  assign o_wb_stall   = i_resetb && (block || (mapped && slave_stall));
  assign accept       = i_resetb && i_wb_cyc && i_wb_stb && !o_wb_stall;
  assign owner_ack    = i_wb_cyc && busy && owner_ack_raw;
  assign unmapped_acc = accept && !mapped;
  assign err_set      = unmapped_acc || timeout_hit;

  always_comb begin
    o_s_stb = '0;
    o_s_cyc = '0;
    for (int k = 0; k < NSLAVES; k++) begin
      o_s_stb[k] = i_resetb && i_wb_cyc && i_wb_stb && mapped &&
                   (sel == OW'(k)) && !block;
      o_s_cyc[k] = i_resetb && i_wb_cyc && (state != ST_ERR) &&
                   ((busy && (owner == OW'(k))) || (mapped && (sel == OW'(k))));
    end
  end

  wb_txn_tracker #(
    .NSLAVES (NSLAVES),
    .AW      (AW),
    .MAX_OUT (MAX_OUT),
    .TIMEOUT (TIMEOUT)
  ) u_tracker (
    .i_clk           (i_clk),
    .i_resetb        (i_resetb),
    .i_cyc           (i_wb_cyc),
    .i_accept        (accept),
    .i_mapped        (mapped),
    .i_slave         (sel),
    .i_addr          (i_wb_addr),
    .i_owner_ack     (owner_ack),
    .o_state         (state),
    .o_outstanding   (outstanding),
    .o_owner         (owner),
    .o_oldest_addr_c (oldest_addr),
    .o_timeout_c     (timeout_hit)
  );

  always_ff @(posedge i_clk) begin
    if (!i_resetb) begin
      o_wb_ack    <= 1'b0;
      o_wb_err    <= 1'b0;
      o_wb_data   <= '0;
      o_err_addr  <= '0;
      o_err_count <= '0;
    end else begin
      o_wb_ack  <= owner_ack;
      o_wb_data <= owner_ack ? owner_data : '0;
      o_wb_err  <= err_set;
      if (err_set) begin
        o_err_addr  <= unmapped_acc ? i_wb_addr : oldest_addr;
        o_err_count <= (o_err_count != 16'hFFFF) ? o_err_count + 16'd1 : o_err_count;
      end
    end
  end

endmodule

// File: tb/tb_wb_slave_decoder.sv
// Directed bench for wb_slave_decoder: inputs change 1 ns after each rising
// edge, outputs are sampled 2 ns after it.
module tb_wb_slave_decoder;

  logic        clk = 1'b0;
  logic        resetb;
  logic        cyc, stb, we;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wsel;
  logic        stall, ack, err;
  logic [31:0] rdata;
  logic [2:0]  s_cyc, s_stb;
  logic        s_we;
  logic [29:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_sel;
  logic [2:0]  s_stall, s_ack;
  logic [95:0] s_data;
  logic [29:0] err_addr;
  logic [15:0] err_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_slave_decoder #(.TIMEOUT(16)) dut (
    .i_clk       (clk),
    .i_resetb    (resetb),
    .i_wb_cyc    (cyc),
    .i_wb_stb    (stb),
    .i_wb_we     (we),
    .i_wb_addr   (addr),
    .i_wb_data   (wdata),
    .i_wb_sel    (wsel),
    .o_wb_stall  (stall),
    .o_wb_ack    (ack),
    .o_wb_err    (err),
    .o_wb_data   (rdata),
    .o_s_cyc     (s_cyc),
    .o_s_stb     (s_stb),
    .o_s_we      (s_we),
    .o_s_addr    (s_addr),
    .o_s_data    (s_wdata),
    .o_s_sel     (s_sel),
    .i_s_stall   (s_stall),
    .i_s_ack     (s_ack),
    .i_s_data    (s_data),
    .o_err_addr  (err_addr),
    .o_err_count (err_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetb = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0;
    addr = 30'h8200; wdata = '0; wsel = 4'hF;
    s_stall = '0; s_ack = '0; s_data = '0;

    // Reset: strobes and stall gated off, registers cleared
    tick(); tick(); #1;
    chk("rst_stall", stall, 0);
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_data", rdata, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_err_count", err_count, 0);
    cyc = 1'b0; stb = 1'b0; addr = '0;
    tick(); resetb = 1'b1;
    tick();

    // Single write to slave 1, acked the next cycle
    tick(); cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'h8204; wdata = 32'hDEADBEEF; #1;
    chk("t1_s_stb", s_stb, 3'b010);
    chk("t1_stall", stall, 0);
    chk("t1_pass_data", s_wdata, 32'hDEADBEEF);
    tick(); stb = 1'b0; we = 1'b0; addr = '0; s_ack = 3'b010; s_data[63:32] = 32'h11111111; #1;
    chk("t1_s_stb_off", s_stb, 0);
    chk("t1_ack_early", ack, 0);
    tick(); s_ack = '0; #1;
    chk("t1_ack", ack, 1);
    chk("t1_data", rdata, 32'h11111111);
    chk("t1_err", err, 0);
    tick(); #1;
    chk("t1_ack_end", ack, 0);
    chk("t1_s_cyc_idle", s_cyc, 0);

    // Four pipelined reads to slave 0, fifth stalls at MAX_OUT
    for (int i = 0; i < 4; i++) begin
      tick(); stb = 1'b1; addr = 30'h8100 + 30'(i); #1;
      chk("t2_no_stall", stall, 0);
    end
    tick(); addr = 30'h8104; s_ack = 3'b001; s_data[31:0] = 32'hC0DE0000; #1;
    chk("t2_full_stall", stall, 1);
    chk("t2_full_s_stb", s_stb, 0);
    chk("t2_no_ack_yet", ack, 0);
    tick(); stb = 1'b0; addr = '0; s_ack = 3'b101; s_data[31:0] = 32'hC0DE0001;
    s_data[95:64] = 32'hBAD0BAD0; #1;
    chk("t2_ack0", ack, 1);
    chk("t2_data0", rdata, 32'hC0DE0000);
    tick(); s_ack = 3'b001; s_data[31:0] = 32'hC0DE0002; #1;
    chk("t2_data1", rdata, 32'hC0DE0001);
    tick(); s_data[31:0] = 32'hC0DE0003; #1;
    chk("t2_data2", rdata, 32'hC0DE0002);
    tick(); s_data[31:0] = 32'h55555555; #1;
    chk("t2_ack3", ack, 1);
    chk("t2_data3", rdata, 32'hC0DE0003);
    tick(); s_ack = '0; #1;
    chk("t2_stray_ack", ack, 0);
    chk("t2_data_zero", rdata, 0);

    // Switching slaves waits for the previous owner to drain
    tick(); stb = 1'b1; addr = 30'h8300; #1;
    chk("t3_s_stb2", s_stb, 3'b100);
    tick(); addr = 30'h8100; #1;
    chk("t3_stall", stall, 1);
    chk("t3_s_stb_held", s_stb, 0);
    chk("t3_s_cyc", s_cyc, 3'b101);
    tick(); s_ack = 3'b100; s_data[95:64] = 32'h22220000; #1;
    chk("t3_stall_ack", stall, 1);
    tick(); s_ack = '0; #1;
    chk("t3_released", stall, 0);
    chk("t3_s_stb0", s_stb, 3'b001);
    chk("t3_ack2", ack, 1);
    chk("t3_data2", rdata, 32'h22220000);
    tick(); stb = 1'b0; addr = '0; s_ack = 3'b001; s_data[31:0] = 32'hA0A0A0A0; #1;
    chk("t3_ack_gap", ack, 0);
    tick(); s_ack = '0; #1;
    chk("t3_ack0", ack, 1);
    chk("t3_data0", rdata, 32'hA0A0A0A0);

    // Unmapped access
    tick(); stb = 1'b1; addr = 30'h100; #1;
    chk("t4_stall", stall, 0);
    chk("t4_s_stb", s_stb, 0);
    chk("t4_s_cyc", s_cyc, 0);
    tick(); stb = 1'b0; addr = '0; #1;
    chk("t4_err", err, 1);
    chk("t4_err_addr", err_addr, 30'h100);
    chk("t4_err_count", err_count, 1);
    chk("t4_ack", ack, 0);
    tick(); #1;
    chk("t4_err_pulse", err, 0);

    // Timeout: slave 0 never acks
    tick(); stb = 1'b1; addr = 30'h8140; #1;
    chk("t5_s_stb", s_stb, 3'b001);
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n == 8) begin stb = 1'b1; addr = 30'h100; end
      else begin stb = 1'b0; addr = '0; end
      #1;
      chk("t5_wait_err", err, 0);
      if (n == 8) chk("t5_unmapped_busy", stall, 1);
    end
    tick(); stb = 1'b1; addr = 30'h8100; s_ack = 3'b001; s_data[31:0] = 32'hFEEDFEED; #1;
    chk("t5_err", err, 1);
    chk("t5_err_addr", err_addr, 30'h8140);
    chk("t5_err_count", err_count, 2);
    chk("t5_err_stall", stall, 1);
    chk("t5_err_s_stb", s_stb, 0);
    tick(); stb = 1'b0; addr = '0; s_ack = '0; #1;
    chk("t5_err_pulse", err, 0);
    chk("t5_late_ack", ack, 0);
    chk("t5_idle_stall", stall, 0);

    // Dropping cyc with two outstanding
    tick(); stb = 1'b1; addr = 30'h8200; #1;
    chk("t6_acc0", stall, 0);
    tick(); addr = 30'h8201; #1;
    chk("t6_acc1", stall, 0);
    tick(); cyc = 1'b0; stb = 1'b0; addr = '0; s_ack = 3'b010; s_data[63:32] = 32'h3333; #1;
    chk("t6_s_cyc_low", s_cyc, 0);
    tick(); cyc = 1'b1; s_ack = '0; stb = 1'b1; addr = 30'h8300; #1;
    chk("t6_no_ack", ack, 0);
    chk("t6_no_err", err, 0);
    chk("t6_stall", stall, 0);
    chk("t6_s_stb", s_stb, 3'b100);
    tick(); stb = 1'b0; addr = '0; s_ack = 3'b100; s_data[95:64] = 32'h4444; #1;
    chk("t6_ack_gap", ack, 0);
    tick(); s_ack = '0; #1;
    chk("t6_ack", ack, 1);
    chk("t6_data", rdata, 32'h4444);

    // Reset in the middle of a transaction
    tick(); stb = 1'b1; addr = 30'h8100; #1;
    chk("t7_s_stb", s_stb, 3'b001);
    tick(); stb = 1'b0; addr = '0; resetb = 1'b0; s_ack = 3'b001; s_data[31:0] = 32'h55; #1;
    chk("t7_rst_stall", stall, 0);
    chk("t7_rst_s_cyc", s_cyc, 0);
    tick(); resetb = 1'b1; s_ack = '0; #1;
    chk("t7_no_ack", ack, 0);
    chk("t7_no_err", err, 0);
    chk("t7_count_clr", err_count, 0);
    chk("t7_addr_clr", err_addr, 0);
    tick(); stb = 1'b1; addr = 30'h8100; #1;
    chk("t7_stall", stall, 0);
    chk("t7_s_stb_new", s_stb, 3'b001);
    tick(); stb = 1'b0; addr = '0; s_ack = 3'b001; s_data[31:0] = 32'h77; #1;
    tick(); s_ack = '0; #1;
    chk("t7_ack", ack, 1);
    chk("t7_data", rdata, 32'h77);

    cyc = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
